// File: rtl/transformer_pkg.sv
// rtl/transformer_pkg.sv - shared defaults and types for the transformer pipeline
package transformer_pkg;
    localparam int DEF_SEQ_LEN   = 8;
    localparam int DEF_EMBED_DIM = 32;
    localparam int DEF_DATA_W    = 16;

    typedef enum logic [1:0] {FILL, PAD, EMIT} loader_state_t;

    typedef logic signed [DEF_DATA_W-1:0] elem_t;
endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed W-bit adder clamped to the representable range
module sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);
    logic signed [W:0] sum;

    assign sum = {a[W-1], a} + {b[W-1], b};

    // The two top bits disagree only when the true sum left the W-bit range.
    always_comb begin
        y = sum[W-1:0];
        if (sum[W] != sum[W-1])
            y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
endmodule

// File: rtl/encoder_frame_loader.sv
// rtl/encoder_frame_loader.sv - streams embeddings plus positional encoding into a padded frame
module encoder_frame_loader
    import transformer_pkg::*;
#(
    parameter int SEQ_LEN   = DEF_SEQ_LEN,
    parameter int EMBED_DIM = DEF_EMBED_DIM,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = $clog2(SEQ_LEN*EMBED_DIM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [DATA_W-1:0]            in_data,
    input  logic                                in_last,
    input  logic                                pe_we,
    input  logic [ADDR_W-1:0]                   pe_addr,
    input  logic signed [DATA_W-1:0]            pe_data,
    output logic                                frame_valid,
    output logic signed [DATA_W-1:0]            frame [SEQ_LEN][EMBED_DIM],
    output logic [$clog2(SEQ_LEN+1)-1:0]        frame_len,
    output logic                                err_partial
);
    localparam int S_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int D_W   = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
    localparam int LEN_W = $clog2(SEQ_LEN+1);
    localparam int DEPTH = SEQ_LEN*EMBED_DIM;

    loader_state_t            state;
    logic [S_W-1:0]           s;
    logic [D_W-1:0]           d;
    logic [S_W-1:0]           s_nxt;
    logic [D_W-1:0]           d_nxt;
    logic [LEN_W-1:0]         len_pend;
    logic [ADDR_W-1:0]        idx;
    logic signed [DATA_W-1:0] pe_tab [DEPTH];
    logic signed [DATA_W-1:0] frame_buf [SEQ_LEN][EMBED_DIM];
    logic signed [DATA_W-1:0] sum_sat;
    logic                     last_d;
    logic                     last_pos;
    logic                     accept;

    assign idx      = ADDR_W'(s) * ADDR_W'(EMBED_DIM) + ADDR_W'(d);
    assign last_d   = (d == D_W'(EMBED_DIM-1));
    assign last_pos = last_d && (s == S_W'(SEQ_LEN-1));
    assign accept   = in_valid && in_ready;
    assign d_nxt    = last_d ? '0 : d + 1'b1;
    assign s_nxt    = last_d ? s + 1'b1 : s;

    // Table read is combinational, so a same-cycle table write is seen only by later accepts.
    sat_add #(.W(DATA_W)) u_sat_add (
        .a (in_data),
        .b (pe_tab[idx]),
        .y (sum_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FILL;
            s           <= '0;
            d           <= '0;
            len_pend    <= '0;
            in_ready    <= 1'b0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            err_partial <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                pe_tab[k] <= '0;
            for (int i = 0; i < SEQ_LEN; i++)
                for (int j = 0; j < EMBED_DIM; j++) begin
                    frame_buf[i][j] <= '0;
                    frame[i][j]     <= '0;
                end
        end else begin
            frame_valid <= 1'b0;
            if (pe_we)
                pe_tab[pe_addr] <= pe_data;

            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        frame_buf[s][d] <= sum_sat;
                        if (last_pos) begin
                            state    <= EMIT;
                            in_ready <= 1'b0;
                            len_pend <= LEN_W'(SEQ_LEN);
                        end else begin
                            s <= s_nxt;
                            d <= d_nxt;
                            if (in_last) begin
                                state    <= PAD;
                                in_ready <= 1'b0;
                                len_pend <= LEN_W'(s) + LEN_W'(1);
                                if (!last_d)
                                    err_partial <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    frame_buf[s][d] <= '0;
                    if (last_pos) begin
                        state <= EMIT;
                    end else begin
                        s <= s_nxt;
                        d <= d_nxt;
                    end
                end
                default: begin
                    // Publish the frame and leave the buffer zeroed for the next sequence.
                    for (int i = 0; i < SEQ_LEN; i++)
                        for (int j = 0; j < EMBED_DIM; j++) begin
                            frame[i][j]     <= frame_buf[i][j];
                            frame_buf[i][j] <= '0;
                        end
                    frame_valid <= 1'b1;
                    frame_len   <= len_pend;
                    s           <= '0;
                    d           <= '0;
                    in_ready    <= 1'b1;
                    state       <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_frame_loader.sv
// tb/tb_encoder_frame_loader.sv - directed self-checking bench for encoder_frame_loader
module tb_encoder_frame_loader;
    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic               pe_we;
    logic [7:0]         pe_addr;
    logic signed [15:0] pe_data;
    logic               frame_valid;
    logic signed [15:0] frame [8][32];
    logic [3:0]         frame_len;
    logic               err_partial;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;
    int acc_cyc = 0;
    int exp_mem [256];

    encoder_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .pe_we       (pe_we),
        .pe_addr     (pe_addr),
        .pe_data     (pe_data),
        .frame_valid (frame_valid),
        .frame       (frame),
        .frame_len   (frame_len),
        .err_partial (err_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int val(input int kind, input int i);
        case (kind)
            0:       return i;
            1:       return (i == 0) ? 32 : (i == 35) ? -32766 : (i == 66) ? 3 : 0;
            2:       return 1000 + i;
            default: return 300 - 3*i;
        endcase
    endfunction

    task automatic set_exp(input int kind, input int n);
        for (int i = 0; i < 256; i++)
            exp_mem[i] = (i < n) ? val(kind, i) : 0;
    endtask

    task automatic send(input int v, input bit lst);
        int t = 0;
        in_valid = 1'b1;
        in_data  = 16'(v);
        in_last  = lst;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready)
            chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic stream(input int kind, input int n, input bit lst, input int max_gap);
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0)
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send(val(kind, i), lst && (i == n-1));
        end
    endtask

    task automatic wait_fv(input int budget);
        int start = fv_cnt;
        int t = 0;
        while (fv_cnt == start && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (fv_cnt == start)
            chk("frame_valid_timeout", 0, 1);
    endtask

    task automatic pe_write(input int a, input int v);
        pe_we   = 1'b1;
        pe_addr = 8'(a);
        pe_data = 16'(v);
        @(negedge clk);
        pe_we   = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int len, input int err);
        for (int s = 0; s < 8; s++)
            for (int d = 0; d < 32; d++)
                chk($sformatf("%s_frame[%0d][%0d]", tag, s, d), int'(frame[s][d]), exp_mem[s*32+d]);
        chk({tag, "_frame_len"}, int'(frame_len), len);
        chk({tag, "_err_partial"}, int'(err_partial), err);
    endtask

    initial begin
        int fv0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        pe_we = 1'b0; pe_addr = '0; pe_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_frame_len", int'(frame_len), 0);
        chk("rst_err_partial", int'(err_partial), 0);
        chk("rst_frame00", int'(frame[0][0]), 0);
        chk("rst_frame731", int'(frame[7][31]), 0);
        rst = 1'b1;

        // full frame, in_last on the final element is ignored
        stream(0, 256, 1'b1, 0);
        chk("full_ready_low", int'(in_ready), 0);
        chk("full_fv_early", int'(frame_valid), 0);
        @(negedge clk);
        chk("full_fv_pulse", int'(frame_valid), 1);
        chk("full_ready_back", int'(in_ready), 1);
        chk("full_fv_latency", fv_cyc - acc_cyc, 1);
        set_exp(0, 256);
        check_frame("full", 8, 0);
        @(negedge clk);
        chk("full_fv_one_cycle", int'(frame_valid), 0);
        chk("full_fv_count", fv_cnt, 1);

        // positional encoding and saturation
        pe_write(0, 32'h7FF0);
        pe_write(35, -5);
        pe_write(66, 7);
        stream(1, 256, 1'b0, 0);
        wait_fv(10);
        for (int i = 0; i < 256; i++) exp_mem[i] = 0;
        exp_mem[0]  = 32767;
        exp_mem[35] = -32768;
        exp_mem[66] = 10;
        check_frame("pe", 8, 0);
        pe_write(0, 0);
        pe_write(35, 0);
        pe_write(66, 0);

        // short sequence: three whole tokens
        stream(0, 96, 1'b1, 0);
        wait_fv(400);
        chk("short_fv_latency", fv_cyc - acc_cyc, 161);
        set_exp(0, 96);
        check_frame("short", 3, 0);

        // in_last mid-token at s=1, d=8
        stream(2, 41, 1'b1, 0);
        wait_fv(400);
        chk("partial_fv_latency", fv_cyc - acc_cyc, 216);
        set_exp(2, 41);
        check_frame("partial", 2, 1);

        // backpressure gaps; err_partial stays set
        stream(0, 256, 1'b0, 3);
        wait_fv(10);
        set_exp(0, 256);
        check_frame("gaps", 8, 1);

        // reset mid-frame discards partial data
        stream(2, 100, 1'b0, 0);
        fv0 = fv_cnt;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_err_cleared", int'(err_partial), 0);
        chk("midrst_ready", int'(in_ready), 0);
        rst = 1'b1;
        stream(3, 256, 1'b0, 0);
        wait_fv(10);
        repeat (5) @(negedge clk);
        chk("midrst_fv_count", fv_cnt - fv0, 1);
        set_exp(3, 256);
        check_frame("midrst", 8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/encoder_frame_loader.md
# encoder_frame_loader

- Upstream stage of `transformer_encoder`.
- Accepts a serial stream of embedding elements over a valid/ready handshake and adds a programmable positional-encoding table with saturation.
- Assembles the elements into a `SEQ_LEN`×`EMBED_DIM` frame and zero-pads short sequences.
- Presents the frame on a registered output with a one-cycle `frame_valid` pulse that drives the encoder's `valid_in`.

## Interface
- `SEQ_LEN`, 8: tokens per frame.
- `EMBED_DIM`, 32: elements per token.
- `DATA_W`, 16: signed element width.
- `ADDR_W`, $clog2(SEQ_LEN*EMBED_DIM): PE table address width.

- `clk`  in  1: the single clock; all logic on posedge.
- `rst`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader accepts an element this cycle.
- `in_data`  in  DATA_W signed: embedding element, token-major (d fastest).
- `in_last`  in  1: qualifies the final element of a sequence.
- `pe_we`  in  1: positional-encoding table write strobe.
- `pe_addr`  in  ADDR_W: table index, s*EMBED_DIM+d.
- `pe_data`  in  DATA_W signed: table write data.
- `frame_valid`  out  1: one-cycle pulse; `frame` is new and complete.
- `frame`  out  DATA_W signed [SEQ_LEN][EMBED_DIM]: assembled frame, held until the next pulse.
- `frame_len`  out  $clog2(SEQ_LEN+1): number of real tokens in `frame`.
- `err_partial`  out  1: sticky flag; a sequence ended mid-token.

## Operation
- **Reset values (rst=0):**
  - `in_ready`=0, `frame_valid`=0, `frame` all 0, `frame_len`=0, `err_partial`=0.
  - PE table all 0, internal buffer all 0, counters s=d=0, state FILL.
- **Accept:** an element is accepted when `in_valid && in_ready`.
  - buf[s][d] <= sat(in_data + pe[s][d]).
  - Advance d; when d wraps from EMBED_DIM-1, advance s.
- **Saturation:** sum computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- **FSM:**
  - FILL: `in_ready`=1.
    - Accepting element (SEQ_LEN-1, EMBED_DIM-1) → EMIT, `frame_len`=SEQ_LEN. `in_last` there is allowed and ignored.
    - Accepting with `in_last`=1 and not at the final position → PAD.
  - PAD: `in_ready`=0. Writes 0 (no PE added) to one remaining position per cycle. After writing (SEQ_LEN-1, EMBED_DIM-1) → EMIT.
  - EMIT: `in_ready`=0. For one cycle, copies buf into `frame`, pulses `frame_valid`, loads `frame_len`, clears s, d and buf → FILL.
- **`frame_len` on `in_last`:** number of tokens with at least one accepted element.
- **`in_last` mid-token** (d≠EMBED_DIM-1): set `err_partial`. The rest of that token and all later tokens are zero-padded. The partial token counts in `frame_len`.
- **PE writes:** allowed in any state.
  - Same-cycle write and accept at the same address: the accept uses the old value.
  - Takes effect for accepts on later cycles.
- **Reset mid-frame:** discards the partial frame. No `frame_valid` is produced for it.

## Timing
- Full frame: last element accepted at edge t → EMIT during cycle t..t+1 → `frame`/`frame_len` update and `frame_valid`=1 for exactly the cycle after edge t+1.
- Short frame with P padding positions: `frame_valid` at P+1 edges after the `in_last` accept.
- `in_ready` is low for exactly 1 (full) or P+1 (short) cycles between frames. First element of the next frame is accepted no earlier than the edge at which `frame_valid` rises.
- `frame` is stable between pulses. The downstream stage may sample it on any cycle after a pulse.
- Element throughput: 1 per cycle in FILL.

## Structure
- Shared package `transformer_pkg`: SEQ_LEN/EMBED_DIM/DATA_W defaults, the `loader_state_t` enum {FILL, PAD, EMIT}, and the `elem_t` signed typedef. `transformer_encoder` imports the same package.
- One sub-module: `sat_add` (parameter W; signed a+b → clamped W-bit result). Combinational; also reused downstream for residual adds.
- PE table and buffer are flop arrays (SEQ_LEN*EMBED_DIM entries each).

## Test plan
- **Full frame:** after reset, PE=0, stream 256 elements with value s*32+d, `in_valid` held high → `frame[s][d]`=s*32+d, `frame_len`=8, one `frame_valid` pulse one cycle after EMIT, `in_ready` low exactly 1 cycle.
- **PE and saturation:**
  - pe[0][0]=0x7FF0 with in=0x0020 → `frame[0][0]`=0x7FFF.
  - pe[1][3]=-5 with in=-0x7FFE → 0x8000.
  - pe[2][2]=7 with in=3 → 10.
- **Short sequence:** 3 full tokens, `in_last` on element 95 → `frame_len`=3, rows 3..7 all 0, `frame_valid` 161 edges after the `in_last` accept, `err_partial`=0.
- **Mid-token `in_last`:** `in_last` at element 40 (s=1, d=8) → `err_partial`=1 (sticky across the next frame), `frame_len`=2, `frame[1][9..31]`=0.
- **Backpressure/reset:**
  - Randomised `in_valid` gaps give a result identical to the first scenario.
  - `rst` asserted after 100 elements, then 256 fresh elements → exactly one `frame_valid`, containing only the new data.
